// File: rtl/str_rec_pkg.sv
// Shared types and defaults for the string-recognition datapath.
package str_rec_pkg;

  localparam int DEF_POS_W   = 7;
  localparam int DEF_PAT_LEN = 4;

  typedef logic [DEF_POS_W-1:0] pos_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/pos_fifo.sv
// First-word fall-through FIFO holding match start positions.
// A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
module pos_fifo
  import str_rec_pkg::*;
#(
  parameter int W     = $bits(pos_t),
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_pop;
  logic          w_push;

  assign empty  = (r_count == '0);
  assign full   = (r_count == (AW+1)'(DEPTH));
  assign w_pop  = pop && !empty;
  assign w_push = push && (!full || w_pop);
  assign rdata  = r_mem[r_rd_ptr];
  assign count  = r_count;

  // NOTE: storage carries no reset; the pointers and count alone define what is valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= wdata;
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/str_match_ctrl.sv
// Sequencing controller: gates characters into the matcher, numbers them,
// and queues match start positions for the downstream consumer.
module str_match_ctrl
  import str_rec_pkg::*;
#(
  parameter int POS_W      = DEF_POS_W,
  parameter int PAT_LEN    = DEF_PAT_LEN,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             char_valid,
  input  logic             char_last,
  output logic             char_ready,
  output logic             mt_en,
  output logic             mt_clear,
  input  logic             match_hit,
  output logic             pos_valid,
  output logic [POS_W-1:0] pos_data,
  input  logic             pos_ready,
  output logic [POS_W-1:0] match_count,
  output logic             overflow,
  output logic             busy,
  output logic             done
);

  localparam logic [POS_W-1:0] MAX_V  = '1;
  localparam logic [POS_W-1:0] OFFSET = POS_W'(PAT_LEN - 1);

  state_t r_state;
  state_t w_next_state;

  logic [POS_W-1:0]            r_pos;
  logic                        w_accept;
  logic                        w_pop;
  logic                        w_start_new;
  logic                        w_pos_sat;
  logic                        w_hit_valid;
  logic                        w_push;
  logic                        w_drop;
  logic [POS_W-1:0]            w_push_data;
  logic                        w_fifo_full;
  logic                        w_fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] w_fifo_count;
  logic                        w_mt_clear_nxt;
  logic                        w_done_nxt;
  logic                        w_busy_nxt;

  assign char_ready  = (r_state == RUN);
  assign mt_en       = char_valid && char_ready;
  assign w_accept    = mt_en;
  assign pos_valid   = !w_fifo_empty;
  assign w_pop       = pos_valid && pos_ready;
  assign w_start_new = (r_state == IDLE) && start;

  // A hit on a saturated counter has no trustworthy index, so it is discarded.
  assign w_pos_sat   = (r_pos == MAX_V);
  assign w_hit_valid = w_accept && match_hit && !w_pos_sat && (r_pos >= OFFSET);
  assign w_push      = w_hit_valid && (!w_fifo_full || w_pop);
  assign w_drop      = w_hit_valid && !w_push;
  assign w_push_data = r_pos - OFFSET;

  pos_fifo #(
    .W     (POS_W),
    .DEPTH (FIFO_DEPTH)
  ) u_pos_fifo (
    .clk   (clk),
    .reset (reset),
    .clear (w_start_new),
    .push  (w_push),
    .pop   (w_pop),
    .wdata (w_push_data),
    .rdata (pos_data),
    .full  (w_fifo_full),
    .empty (w_fifo_empty),
    .count (w_fifo_count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  // NOTE: the default assignment up front keeps this block free of inferred latches.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (start) w_next_state = CLEAR;
      CLEAR:   w_next_state = RUN;
      RUN:     if (w_accept && char_last) w_next_state = DRAIN;
      DRAIN:   if (w_fifo_count == '0) w_next_state = DONE;
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Registered outputs are decoded from the upcoming state so they align with it.
  always_comb begin
    w_mt_clear_nxt = (w_next_state == CLEAR);
    w_done_nxt     = (w_next_state == DONE);
    w_busy_nxt     = (w_next_state != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mt_clear <= 1'b0;
      done     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      mt_clear <= w_mt_clear_nxt;
      done     <= w_done_nxt;
      busy     <= w_busy_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pos       <= '0;
      match_count <= '0;
      overflow    <= 1'b0;
    end else if (w_start_new) begin
      r_pos       <= '0;
      match_count <= '0;
      overflow    <= 1'b0;
    end else begin
      if (w_accept && !w_pos_sat)      r_pos <= r_pos + 1'b1;
      if (w_push && match_count != MAX_V) match_count <= match_count + 1'b1;
      if (w_drop || (w_accept && w_pos_sat)) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_str_match_ctrl.sv
// Scoreboard bench for str_match_ctrl: expected start positions are queued as hits are driven
// and compared when the controller presents them.
module tb_str_match_ctrl;
  import str_rec_pkg::*;

  localparam int POS_W   = 7;
  localparam int PAT_LEN = 4;
  localparam int DEPTH   = 4;
  localparam int MAXV    = 127;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             char_valid;
  logic             char_last;
  logic             char_ready;
  logic             mt_en;
  logic             mt_clear;
  logic             match_hit;
  logic             pos_valid;
  pos_t             pos_data;
  logic             pos_ready;
  logic [POS_W-1:0] match_count;
  logic             overflow;
  logic             busy;
  logic             done;

  int   n_checks = 0;
  int   n_errors = 0;
  int   n_clear;
  int   n_done;
  int   m_idx;
  int   m_cnt;
  bit   m_ovf;
  bit   mon_en = 1'b0;
  int   sb[$];

  always #5 clk = ~clk;

  str_match_ctrl #(
    .POS_W      (POS_W),
    .PAT_LEN    (PAT_LEN),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .char_valid  (char_valid),
    .char_last   (char_last),
    .char_ready  (char_ready),
    .mt_en       (mt_en),
    .mt_clear    (mt_clear),
    .match_hit   (match_hit),
    .pos_valid   (pos_valid),
    .pos_data    (pos_data),
    .pos_ready   (pos_ready),
    .match_count (match_count),
    .overflow    (overflow),
    .busy        (busy),
    .done        (done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model and scoreboard, evaluated mid-cycle on stable inputs.
  always @(negedge clk) begin
    bit pop_e;
    if (mon_en && !reset) begin
      pop_e = (sb.size() > 0) && pos_ready;
      check("pos_valid", pos_valid, sb.size() > 0);
      check("mt_en", mt_en, char_valid && char_ready);
      if (pop_e) begin
        check("pos_data", pos_data, sb[0]);
        void'(sb.pop_front());
      end
      if (char_valid && char_ready) begin
        if (match_hit && m_idx >= PAT_LEN-1 && m_idx < MAXV) begin
          if (sb.size() < DEPTH) begin
            sb.push_back(m_idx - (PAT_LEN-1));
            if (m_cnt < MAXV) m_cnt++;
          end else begin
            m_ovf = 1'b1;
          end
        end
        if (m_idx == MAXV) m_ovf = 1'b1;
        else               m_idx++;
      end
      if (mt_clear) n_clear++;
      if (done)     n_done++;
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_char_ready"}, char_ready, 0);
    check({tag, "_mt_clear"}, mt_clear, 0);
    check({tag, "_pos_valid"}, pos_valid, 0);
    check({tag, "_match_count"}, match_count, 0);
    check({tag, "_overflow"}, overflow, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
  endtask

  // All stimulus tasks begin and end just after a rising edge.
  task automatic start_string();
    m_idx = 0; m_cnt = 0; m_ovf = 1'b0; n_clear = 0; n_done = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("clear_pulse", mt_clear, 1);
    check("clear_busy", busy, 1);
    check("clear_no_ready", char_ready, 0);
    @(posedge clk); #1;
  endtask

  task automatic send_char(input bit last, input bit hit);
    bit got;
    char_valid = 1'b1; char_last = last; match_hit = hit;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = char_ready;
    end
    if (!got) check("char_ready_timeout", 0, 1);
    @(posedge clk); #1;
    char_valid = 1'b0; char_last = 1'b0; match_hit = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      seen = done;
    end
    check({tag, "_done_seen"}, seen, 1);
    @(posedge clk); #1;
    @(negedge clk);
    check({tag, "_idle_busy"}, busy, 0);
    check({tag, "_idle_done"}, done, 0);
    check({tag, "_done_once"}, n_done, 1);
    check({tag, "_clear_once"}, n_clear, 1);
    check({tag, "_sb_empty"}, sb.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic run_basic(input string tag);
    pos_ready = 1'b1;
    start_string();
    for (int i = 0; i < 10; i++) send_char(i == 9, i == 5 || i == 9);
    check({tag, "_count"}, match_count, 2);
    check({tag, "_ovf"}, overflow, 0);
    wait_done(tag, 40);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; char_valid = 1'b0; char_last = 1'b0;
    match_hit = 1'b0; pos_ready = 1'b0;
    #1;
    check_all_zero("rst");
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    mon_en = 1'b1;
    @(posedge clk); #1;

    // Basic two-hit string: starts 2 and 6.
    run_basic("s1");

    // Hit on index 2 is too early to have a full pattern behind it.
    pos_ready = 1'b1;
    start_string();
    for (int i = 0; i < 5; i++) send_char(i == 4, i == 2);
    check("s2_count", match_count, 0);
    check("s2_ovf", overflow, 0);
    wait_done("s2", 40);

    // FIFO fills, fifth hit dropped, controller waits in DRAIN.
    pos_ready = 1'b0;
    start_string();
    for (int i = 0; i < 8; i++) send_char(i == 7, i >= 3);
    check("s3_count", match_count, 4);
    check("s3_ovf", overflow, 1);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("s3_drain_busy", busy, 1);
    check("s3_drain_ready", char_ready, 0);
    check("s3_stray_start", mt_clear, 0);
    check("s3_no_done", n_done, 0);
    check("s3_head", pos_data, 0);
    @(posedge clk); #1;
    pos_ready = 1'b1;
    wait_done("s3", 40);

    // Full FIFO with simultaneous pop and push at index 7.
    pos_ready = 1'b0;
    start_string();
    for (int i = 0; i < 7; i++) send_char(1'b0, i >= 3);
    pos_ready = 1'b1;
    send_char(1'b0, 1'b1);
    check("s4_count", match_count, 5);
    check("s4_ovf", overflow, 0);
    send_char(1'b1, 1'b0);
    wait_done("s4", 40);

    // Reset mid-run with two queued entries.
    pos_ready = 1'b0;
    start_string();
    for (int i = 0; i < 5; i++) send_char(1'b0, i >= 3);
    check("s5_queued", pos_valid, 1);
    #2 reset = 1'b1;
    #1;
    check_all_zero("s5_rst");
    sb.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    run_basic("s5b");

    // Position counter saturation.
    pos_ready = 1'b1;
    start_string();
    for (int i = 0; i < 130; i++) send_char(1'b0, 1'b0);
    check("s6_ovf", overflow, 1);
    check("s6_count_pre", match_count, 0);
    send_char(1'b0, 1'b1);
    check("s6_count_post", match_count, 0);
    @(negedge clk);
    check("s6_no_pos", pos_valid, 0);
    @(posedge clk); #1;
    send_char(1'b1, 1'b0);
    check("s6_ovf_end", overflow, 1);
    wait_done("s6", 40);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end

endmodule
